// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line plus go/dr handshake between a consumer and uart_rx
interface uart_rx_if;
  logic       rx;
  logic       go;
  logic [7:0] data;
  logic       dr;
  modport master (output rx, go, input data, dr);
  modport slave (input rx, go, output data, dr);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first UART receiver with go/dr handshake; define UART_RX_SYNC_EN to add a 2-flop rx synchronizer
module uart_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600
) (
  input logic      clk,
  input logic      rst,
  uart_rx_if.slave bus
);
  localparam int BIT_TIME = CLK_FREQ / BAUD_RATE;
  localparam int HALF     = BIT_TIME / 2;
  localparam int CW       = $clog2(BIT_TIME + 1);
  typedef enum logic [2:0] {IDLE, WAIT_START, START, DATA, STOP, READY} state_t;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_data;
  logic          r_dr;
  logic          w_rxs;
  logic          w_half;
  logic          w_full;
`ifdef UART_RX_SYNC_EN
  logic [1:0] r_sync;
  // two-flop synchronizer, reset idle-high so leaving reset never looks like a start bit
  always_ff @(posedge clk) r_sync <= rst ? 2'b11 : {r_sync[0], bus.rx};
  assign w_rxs = r_sync[1];
`else
  assign w_rxs = bus.rx;
`endif
  // the counter restarts at every sample point, so these mark the next one
  assign w_half   = r_cnt == CW'(HALF - 1);
  assign w_full   = r_cnt == CW'(BIT_TIME - 1);
  assign bus.data = r_data;
  assign bus.dr   = r_dr;
  // frame FSM: start detect, mid-bit sampling, stop check and hold-until-ack
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_data  <= 8'h00;
      r_dr    <= 1'b0;
    end else
      case (r_state)
        IDLE: begin
          r_dr <= 1'b0;
          if (bus.go) r_state <= WAIT_START;
        end
        WAIT_START:
          if (!bus.go) r_state <= IDLE;
          else if (!w_rxs) begin
            r_cnt   <= '0;
            r_state <= START;
          end
        START:
          if (!bus.go) r_state <= IDLE;
          else if (w_half) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= w_rxs ? WAIT_START : DATA;
          end else r_cnt <= r_cnt + CW'(1);
        DATA:
          if (!bus.go) r_state <= IDLE;
          else if (w_full) begin
            r_cnt  <= '0;
            r_data <= {w_rxs, r_data[7:1]};
            r_bit  <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= STOP;
          end else r_cnt <= r_cnt + CW'(1);
        STOP:
          if (!bus.go) r_state <= IDLE;
          else if (w_full) begin
            r_cnt   <= '0;
            r_state <= w_rxs ? READY : WAIT_START;
            r_dr    <= w_rxs;
          end else r_cnt <= r_cnt + CW'(1);
        READY:
          if (!bus.go) begin
            r_dr    <= 1'b0;
            r_state <= IDLE;
          end
        default: r_state <= IDLE;
      endcase
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames checked against a frame-level model of delivered bytes and dr timing
module tb_uart_rx;
  localparam int BT = 10;
`ifdef UART_RX_SYNC_EN
  localparam int LAT = 98;
  localparam int GAP = 3;
`else
  localparam int LAT = 96;
  localparam int GAP = 0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  uart_rx_if bus();
  uart_rx #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n = 0;
  int errs = 0;
  int cyc = 0;
  logic dr_q = 1'b0;
  logic [7:0] exp_data[$];
  int exp_cyc[$];
  logic [7:0] got_data[$];
  int got_cyc[$];
  always #5 clk = ~clk;
  // cycle count used to timestamp start edges and dr rises
  always @(posedge clk) cyc <= cyc + 1;
  // record every delivered byte and the cycle its dr rose
  always @(negedge clk) begin
    if (bus.dr === 1'b1 && dr_q !== 1'b1) begin
      got_data.push_back(bus.data);
      got_cyc.push_back(cyc);
    end
    dr_q = bus.dr;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [7:0] b, input logic stop, input logic deliver);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    if (deliver) begin
      exp_data.push_back(b);
      exp_cyc.push_back(cyc + LAT);
    end
    for (int i = 0; i < 10; i++) begin
      bus.rx = f[i];
      tick(BT);
    end
    bus.rx = 1'b1;
  endtask
  task automatic ack();
    int w;
    w = 0;
    while (bus.dr !== 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("ack_dr_seen", bus.dr, 1'b1);
    @(posedge clk);
    #1 bus.go = 1'b0;
    @(posedge clk);
    #1 bus.go = 1'b1;
  endtask
  task automatic verify(input string tag);
    chk({tag, "_count"}, got_data.size(), exp_data.size());
    while (got_data.size() > 0 && exp_data.size() > 0) begin
      chk({tag, "_data"}, got_data.pop_front(), exp_data.pop_front());
      chk({tag, "_dr_cycle"}, got_cyc.pop_front(), exp_cyc.pop_front());
    end
    got_data.delete();
    got_cyc.delete();
    exp_data.delete();
    exp_cyc.delete();
  endtask
  initial begin
    logic [7:0] b;
    logic st;
    bus.rx = 1'b1;
    bus.go = 1'b0;
    tick(3);
    chk("reset_dr", bus.dr, 1'b0);
    chk("reset_data", bus.data, 8'h00);
    rst = 1'b0;
    bus.go = 1'b1;
    tick(200);
    chk("idle_dr", bus.dr, 1'b0);
    verify("idle");
    send(8'hA5, 1'b1, 1'b1);
    chk("a5_dr_held", bus.dr, 1'b1);
    tick(7);
    chk("a5_dr_still", bus.dr, 1'b1);
    chk("a5_data_stable", bus.data, 8'hA5);
    bus.go = 1'b0;
    tick(1);
    chk("a5_ack_dr", bus.dr, 1'b0);
    chk("a5_ack_data_kept", bus.data, 8'hA5);
    bus.go = 1'b1;
    tick(5);
    verify("a5");
    fork
      begin
        send(8'h3C, 1'b1, 1'b1);
        tick(GAP);
        send(8'hC3, 1'b1, 1'b1);
      end
      begin
        ack();
        ack();
      end
    join
    tick(5);
    verify("b2b");
    bus.rx = 1'b0;
    tick(3);
    bus.rx = 1'b1;
    tick(20);
    chk("glitch_dr", bus.dr, 1'b0);
    send(8'h55, 1'b1, 1'b1);
    ack();
    tick(5);
    verify("glitch");
    send(8'hFF, 1'b0, 1'b0);
    tick(20);
    chk("frame_err_dr", bus.dr, 1'b0);
    chk("frame_err_data", bus.data, 8'hFF);
    send(8'h12, 1'b1, 1'b1);
    ack();
    tick(5);
    verify("frame_err");
    fork
      send(8'h5A, 1'b1, 1'b0);
      begin
        tick(40);
        bus.go = 1'b0;
      end
    join
    tick(5);
    chk("abort_dr", bus.dr, 1'b0);
    bus.go = 1'b1;
    tick(5);
    verify("abort");
    fork
      send(8'hE7, 1'b1, 1'b0);
      begin
        tick(50);
        bus.go = 1'b0;
        rst = 1'b1;
        tick(1);
        chk("midreset_data", bus.data, 8'h00);
        chk("midreset_dr", bus.dr, 1'b0);
        rst = 1'b0;
      end
    join
    tick(5);
    bus.go = 1'b1;
    tick(5);
    verify("midreset");
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      st = $urandom_range(0, 3) != 0;
      tick(12 + $urandom_range(0, 30));
      send(b, st, st);
      if (st) ack();
    end
    tick(20);
    verify("random");
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
